latch_bus_sequencer: RTL and testbench

Cycle sequencer for the two byte-lane octal-latch pairs between the 16-bit CPU data bus and the graphics-chip data bus. It drives the latch-enable and output-enable controls of the write pair (CPU→chip) and the read pair (chip→CPU), issues the chip access strobe, waits for chip ready with a bounded timeout, and returns the CPU acknowledge. All outputs are registered; one clock domain.

---
 rtl/latch_bus_sequencer_if.sv | 34 +++
 rtl/latch_bus_sequencer.sv | 153 +++++++++++++++
 tb/tb_latch_bus_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/latch_bus_sequencer_if.sv
// Bus bundle between the CPU-side request logic and the latch sequencer.
// Carries request/select inputs, chip ready, and every latch/strobe/ack control.
interface latch_bus_sequencer_if;
  logic cpu_req;
  logic cpu_rw;
  logic cpu_uds;
  logic cpu_lds;
  logic vga_ready;
  logic le_wr_hi;
  logic le_wr_lo;
  logic oe_wr_hi_n;
  logic oe_wr_lo_n;
  logic le_rd_hi;
  logic le_rd_lo;
  logic oe_rd_hi_n;
  logic oe_rd_lo_n;
  logic vga_strobe;
  logic cpu_dtack;
  logic bus_err;

  modport slave (
    input  cpu_req, cpu_rw, cpu_uds, cpu_lds, vga_ready,
    output le_wr_hi, le_wr_lo, oe_wr_hi_n, oe_wr_lo_n,
    output le_rd_hi, le_rd_lo, oe_rd_hi_n, oe_rd_lo_n,
    output vga_strobe, cpu_dtack, bus_err
  );

  modport master (
    output cpu_req, cpu_rw, cpu_uds, cpu_lds, vga_ready,
    input  le_wr_hi, le_wr_lo, oe_wr_hi_n, oe_wr_lo_n,
    input  le_rd_hi, le_rd_lo, oe_rd_hi_n, oe_rd_lo_n,
    input  vga_strobe, cpu_dtack, bus_err
  );
endinterface

// File: rtl/latch_bus_sequencer.sv
// Sequences the write/read octal-latch pairs between the CPU bus and the graphics chip.
// Outputs are registered from the next-state decode, so they change cleanly on the edge.
module latch_bus_sequencer #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned TIMEOUT   = 255
) (
  input logic                  clk,
  input logic                  reset,
  latch_bus_sequencer_if.slave bus
);
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] SETUP_LIM   = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_ACK, S_RECOVER
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic             rw_q, rw_d, hi_q, hi_d, lo_q, lo_d;
  logic             timeout;
  logic             le_wr_hi_d, le_wr_lo_d, oe_wr_hi_n_d, oe_wr_lo_n_d;
  logic             le_rd_hi_d, le_rd_lo_d, oe_rd_hi_n_d, oe_rd_lo_n_d;
  logic             strobe_d, dtack_d, bus_err_d;

  // Shared per-state cycle counter; saturates instead of wrapping
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      rw_q           <= 1'b0;
      hi_q           <= 1'b0;
      lo_q           <= 1'b0;
      bus.le_wr_hi   <= 1'b0;
      bus.le_wr_lo   <= 1'b0;
      bus.oe_wr_hi_n <= 1'b1;
      bus.oe_wr_lo_n <= 1'b1;
      bus.le_rd_hi   <= 1'b0;
      bus.le_rd_lo   <= 1'b0;
      bus.oe_rd_hi_n <= 1'b1;
      bus.oe_rd_lo_n <= 1'b1;
      bus.vga_strobe <= 1'b0;
      bus.cpu_dtack  <= 1'b0;
      bus.bus_err    <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      rw_q           <= rw_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      bus.le_wr_hi   <= le_wr_hi_d;
      bus.le_wr_lo   <= le_wr_lo_d;
      bus.oe_wr_hi_n <= oe_wr_hi_n_d;
      bus.oe_wr_lo_n <= oe_wr_lo_n_d;
      bus.le_rd_hi   <= le_rd_hi_d;
      bus.le_rd_lo   <= le_rd_lo_d;
      bus.oe_rd_hi_n <= oe_rd_hi_n_d;
      bus.oe_rd_lo_n <= oe_rd_lo_n_d;
      bus.vga_strobe <= strobe_d;
      bus.cpu_dtack  <= dtack_d;
      bus.bus_err    <= bus_err_d;
    end
  end

  // Next state; a dropped request aborts SETUP/STROBE before anything else
  always_comb begin
    state_d = state;
    cnt_d   = '0;
    rw_d    = rw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    timeout = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.cpu_req && (bus.cpu_uds || bus.cpu_lds)) begin
          state_d = S_SETUP;
          rw_d    = bus.cpu_rw;
          hi_d    = bus.cpu_uds;
          lo_d    = bus.cpu_lds;
        end
      end
      S_SETUP: begin
        if (!bus.cpu_req)             state_d = S_RECOVER;
        else if (cnt_inc >= SETUP_LIM) state_d = S_STROBE;
        else                           cnt_d   = cnt_inc;
      end
      S_STROBE: begin
        if (!bus.cpu_req) begin
          state_d = S_RECOVER;
        end else if (bus.vga_ready) begin
          state_d = S_ACK;
        end else if (cnt_inc >= TIMEOUT_LIM) begin
          state_d = S_ACK;
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ACK:     if (!bus.cpu_req) state_d = S_IDLE;
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode of the state being entered; only selected lanes ever activate
  always_comb begin
    le_wr_hi_d   = 1'b0;
    le_wr_lo_d   = 1'b0;
    oe_wr_hi_n_d = 1'b1;
    oe_wr_lo_n_d = 1'b1;
    le_rd_hi_d   = 1'b0;
    le_rd_lo_d   = 1'b0;
    oe_rd_hi_n_d = 1'b1;
    oe_rd_lo_n_d = 1'b1;
    strobe_d     = 1'b0;
    dtack_d      = 1'b0;
    bus_err_d    = 1'b0;
    unique case (state_d)
      S_SETUP: begin
        if (!rw_d) begin
          le_wr_hi_d   = hi_d;
          le_wr_lo_d   = lo_d;
          oe_wr_hi_n_d = !hi_d;
          oe_wr_lo_n_d = !lo_d;
        end
      end
      S_STROBE: begin
        strobe_d = 1'b1;
        if (rw_d) begin
          le_rd_hi_d = hi_d;
          le_rd_lo_d = lo_d;
        end else begin
          oe_wr_hi_n_d = !hi_d;
          oe_wr_lo_n_d = !lo_d;
        end
      end
      S_ACK: begin
        dtack_d   = 1'b1;
        bus_err_d = (state == S_ACK) ? bus.bus_err : timeout;
        if (rw_d) begin
          oe_rd_hi_n_d = !hi_d;
          oe_rd_lo_n_d = !lo_d;
        end
      end
      default: begin
      end
    endcase
  end
endmodule

// File: tb/tb_latch_bus_sequencer.sv
// Scoreboard bench for latch_bus_sequencer (SETUP_CYC=1, TIMEOUT=8).
// Driver pushes expected per-cycle summaries; a negedge monitor pops on each dtack rise.
module tb_latch_bus_sequencer;
  logic clk = 1'b0;
  logic reset;

  latch_bus_sequencer_if bus ();

  latch_bus_sequencer #(.SETUP_CYC(1), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int err;
    int lat;
    int strobe;
    int lwh, lwl, owh, owl, lrh, lrl;
    int ack_owh_n, ack_owl_n, ack_orh_n, ack_orl_n;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   n_push = 0;
  int   dtack_rises = 0;
  int   violations = 0;
  bit   sel_hi = 1'b0;
  bit   sel_lo = 1'b0;

  localparam logic [10:0] IDLE_OUTS = 11'b00110011000;

  function automatic logic [10:0] outs();
    return {bus.le_wr_hi, bus.le_wr_lo, bus.oe_wr_hi_n, bus.oe_wr_lo_n,
            bus.le_rd_hi, bus.le_rd_lo, bus.oe_rd_hi_n, bus.oe_rd_lo_n,
            bus.vga_strobe, bus.cpu_dtack, bus.bus_err};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: accumulate activity while a request is pending, compare on dtack rise
  int  c_lat, c_str, c_lwh, c_lwl, c_owh, c_owl, c_lrh, c_lrl;
  bit  dtack_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if ((!bus.oe_wr_hi_n || !bus.oe_wr_lo_n) && (!bus.oe_rd_hi_n || !bus.oe_rd_lo_n)) violations++;
    if (!sel_hi && (bus.le_wr_hi || bus.le_rd_hi || !bus.oe_wr_hi_n || !bus.oe_rd_hi_n)) violations++;
    if (!sel_lo && (bus.le_wr_lo || bus.le_rd_lo || !bus.oe_wr_lo_n || !bus.oe_rd_lo_n)) violations++;
    if (bus.vga_strobe && bus.cpu_dtack) violations++;
    if (bus.cpu_dtack && !dtack_prev) begin
      dtack_rises++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_dtack: got dtack with empty scoreboard");
      end else begin
        e = q.pop_front();
        chk("latency",   c_lat, e.lat);
        chk("strobe",    c_str, e.strobe);
        chk("le_wr_hi",  c_lwh, e.lwh);
        chk("le_wr_lo",  c_lwl, e.lwl);
        chk("oe_wr_hi",  c_owh, e.owh);
        chk("oe_wr_lo",  c_owl, e.owl);
        chk("le_rd_hi",  c_lrh, e.lrh);
        chk("le_rd_lo",  c_lrl, e.lrl);
        chk("bus_err",   int'(bus.bus_err), e.err);
        chk("ack_oe_wr_hi_n", int'(bus.oe_wr_hi_n), e.ack_owh_n);
        chk("ack_oe_wr_lo_n", int'(bus.oe_wr_lo_n), e.ack_owl_n);
        chk("ack_oe_rd_hi_n", int'(bus.oe_rd_hi_n), e.ack_orh_n);
        chk("ack_oe_rd_lo_n", int'(bus.oe_rd_lo_n), e.ack_orl_n);
      end
    end
    if (!bus.cpu_req || reset) begin
      c_lat = 0; c_str = 0; c_lwh = 0; c_lwl = 0; c_owh = 0; c_owl = 0; c_lrh = 0; c_lrl = 0;
    end else if (!bus.cpu_dtack) begin
      c_lat++;
      c_str += int'(bus.vga_strobe);
      c_lwh += int'(bus.le_wr_hi);
      c_lwl += int'(bus.le_wr_lo);
      c_owh += int'(!bus.oe_wr_hi_n);
      c_owl += int'(!bus.oe_wr_lo_n);
      c_lrh += int'(bus.le_rd_hi);
      c_lrl += int'(bus.le_rd_lo);
    end
    dtack_prev = bus.cpu_dtack;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int err, lat, strb, lwh, lwl, owh, owl, lrh, lrl,
                      input int awh, awl, arh, arl);
    exp_t e;
    e.err = err; e.lat = lat; e.strobe = strb;
    e.lwh = lwh; e.lwl = lwl; e.owh = owh; e.owl = owl; e.lrh = lrh; e.lrl = lrl;
    e.ack_owh_n = awh; e.ack_owl_n = awl; e.ack_orh_n = arh; e.ack_orl_n = arl;
    q.push_back(e);
    n_push++;
  endtask

  task automatic start_req(input bit rw, input bit hi, input bit lo, input bit rdy);
    bus.cpu_rw    = rw;
    bus.cpu_uds   = hi;
    bus.cpu_lds   = lo;
    sel_hi        = hi;
    sel_lo        = lo;
    bus.vga_ready = rdy;
    bus.cpu_req   = 1'b1;
  endtask

  task automatic end_req();
    bus.cpu_req   = 1'b0;
    bus.vga_ready = 1'b0;
    step();
    step();
    sel_hi = 1'b0;
    sel_lo = 1'b0;
  endtask

  // ready_at: -1 high from the start, 0 never, n raised to be sampled at the nth STROBE edge
  task automatic run(input bit rw, input bit hi, input bit lo, input int ready_at, input int hold);
    int k;
    bit done;
    k = 0;
    done = 1'b0;
    start_req(rw, hi, lo, ready_at < 0);
    for (int i = 0; i < 100 && !done; i++) begin
      step();
      if (bus.cpu_dtack) done = 1'b1;
      else if (bus.vga_strobe) begin
        k++;
        if (k == ready_at) bus.vga_ready = 1'b1;
      end
    end
    chk("dtack_arrived", int'(done), 1);
    repeat (hold) step();
    if (hold > 0) chk("dtack_held", int'(bus.cpu_dtack), 1);
    end_req();
  endtask

  // Run into the 2nd STROBE cycle without ready, for abort/reset scenarios
  task automatic reach_strobe2();
    int k;
    k = 0;
    start_req(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && k < 2; i++) begin
      step();
      if (bus.vga_strobe) k++;
    end
    chk("reached_strobe2", k, 2);
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_rw = 1'b0; bus.cpu_uds = 1'b0;
    bus.cpu_lds = 1'b0; bus.vga_ready = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    chk("reset_outs", int'(outs()), int'(IDLE_OUTS));
    chk("reset_cnt",  int'(dut.cnt), 0);

    // Word write, ready already high
    push(0, 3, 1, 1, 1, 2, 2, 0, 0, 1, 1, 1, 1);
    run(1'b0, 1'b1, 1'b1, -1, 0);

    // Low-byte read, ready on 4th STROBE cycle
    push(0, 6, 4, 0, 0, 0, 0, 0, 4, 1, 1, 1, 0);
    run(1'b1, 1'b0, 1'b1, 4, 0);

    // High-byte write, ready never: timeout after 8 STROBE cycles
    push(1, 10, 8, 1, 0, 9, 0, 0, 0, 1, 1, 1, 1);
    run(1'b0, 1'b1, 1'b0, 0, 0);

    // Word read, ready on the 8th (last) STROBE cycle wins over timeout
    push(0, 10, 8, 0, 0, 0, 0, 8, 8, 1, 1, 0, 0);
    run(1'b1, 1'b1, 1'b1, 8, 0);

    // Abort in 2nd STROBE cycle: one RECOVER with idle outputs, then IDLE
    reach_strobe2();
    bus.cpu_req = 1'b0;
    step();
    chk("abort_recover_outs", int'(outs()), int'(IDLE_OUTS));
    step();
    chk("abort_idle_outs", int'(outs()), int'(IDLE_OUTS));
    sel_hi = 1'b0; sel_lo = 1'b0;
    push(0, 3, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1);
    run(1'b1, 1'b1, 1'b0, -1, 0);

    // Request held through ACK: single dtack
    push(0, 3, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0);
    run(1'b1, 1'b1, 1'b1, -1, 5);

    // No byte selected: request ignored
    start_req(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) step();
    chk("ignore_outs", int'(outs()), int'(IDLE_OUTS));
    end_req();

    // Reset mid-STROBE for two cycles
    reach_strobe2();
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    step();
    chk("midreset_outs", int'(outs()), int'(IDLE_OUTS));
    chk("midreset_cnt",  int'(dut.cnt), 0);
    step();
    reset = 1'b0;
    sel_hi = 1'b0; sel_lo = 1'b0;
    step();
    chk("post_reset_outs", int'(outs()), int'(IDLE_OUTS));

    // Normal cycle after reset
    push(0, 3, 1, 0, 1, 0, 2, 0, 0, 1, 1, 1, 1);
    run(1'b0, 1'b0, 1'b1, -1, 0);

    step(); step();
    chk("scoreboard_empty", q.size(), 0);
    chk("dtack_count",      dtack_rises, n_push);
    chk("lane_violations",  violations, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
